// File: rtl/pma_pkg.sv
// ---------------------------------------------------------------------------
// pma_pkg
// Shared types for the programmable physical-memory-attribute table.
//   pma_attr_t       : packed attribute set {l, x, i, c}
//   pma_field_e      : configuration field selector (base, length, attr)
//   pma_entry_t      : one table entry (base, length, attributes)
//   PMA_ATTR_DEFAULT : attributes reported on a lookup miss
// ---------------------------------------------------------------------------
package pma_pkg;

    // Widest physical address an entry can hold; AddrWidth must not exceed it.
    localparam int unsigned PMA_MAX_AW = 64;

    typedef struct packed {
        logic l;  // lock: entry is read-only until reset
        logic x;  // executable
        logic i;  // idempotent
        logic c;  // cacheable
    } pma_attr_t;

    typedef enum logic [1:0] {
        BASE = 2'd0,
        LEN  = 2'd1,
        ATTR = 2'd2
    } pma_field_e;

    typedef struct packed {
        logic [PMA_MAX_AW-1:0] base;
        logic [PMA_MAX_AW-1:0] len;
        pma_attr_t             attr;
    } pma_entry_t;

    // Miss: uncached, non-idempotent, non-executable.
    localparam pma_attr_t PMA_ATTR_DEFAULT = '0;

    // The lookup response carries {X,I,C}; the lock bit stays internal.
    function automatic logic [2:0] pma_resp_attr(input pma_attr_t attr);
        return {attr.x, attr.i, attr.c};
    endfunction

endpackage

// File: rtl/pma_match.sv
// ---------------------------------------------------------------------------
// pma_match
// Combinational single-entry range comparator: hit when base <= addr < base+len.
//   addr_i : physical address under test
//   base_i : entry base address
//   len_i  : entry length (0 disables the entry)
//   hit_o  : address falls inside the entry
// ---------------------------------------------------------------------------
module pma_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] len_i,
    output logic                 hit_o
);

    // The exclusive end is kept one bit wider so a region that runs past the
    // top of the address space does not wrap around and swallow low addresses.
    logic [AddrWidth:0] end_excl;

    assign end_excl = {1'b0, base_i} + {1'b0, len_i};
    assign hit_o    = (len_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < end_excl);

endmodule

// File: rtl/pma_region_table.sv
// ---------------------------------------------------------------------------
// pma_region_table
// Runtime-programmable PMA table with a one-stage registered lookup pipeline
// and a single-cycle configuration port with a registered response.
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   cfg_req_i/cfg_we_i           : config access pulse, 1 = write
//   cfg_idx_i/cfg_field_i        : entry index, field (0 base, 1 len, 2 attr)
//   cfg_wdata_i                  : write data (attr uses bits [3:0])
//   cfg_rvalid_o/rdata_o/err_o   : config response, one cycle after request
//   lookup_valid_i/ready_o/addr_i: lookup request handshake
//   resp_valid_o/ready_i         : lookup response handshake
//   resp_hit_o/idx_o/attr_o      : winning entry, {X,I,C}; zeros on miss
// ---------------------------------------------------------------------------
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned                          NrRegions = 8,
    parameter int unsigned                          AddrWidth = 64,
    parameter logic [NrRegions-1:0][AddrWidth-1:0]  RstBase   = '0,
    parameter logic [NrRegions-1:0][AddrWidth-1:0]  RstLen    = '0,
    parameter logic [NrRegions-1:0][3:0]            RstAttr   = '0,
    localparam int unsigned IdxWidth = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    output logic                 lookup_ready_o,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_hit_o,
    output logic [IdxWidth-1:0]  resp_idx_o,
    output logic [2:0]           resp_attr_o
);

    pma_entry_t             table_q [NrRegions];
    logic [NrRegions-1:0]   match_hit;

    logic                   sel_hit;
    logic [IdxWidth-1:0]    sel_idx;
    pma_attr_t              sel_attr;

    pma_entry_t             cfg_entry;
    logic                   cfg_idx_ok;
    logic                   cfg_err;
    logic                   cfg_wr_en;
    logic [AddrWidth-1:0]   cfg_rd_val;

    // One comparator per entry; all evaluate the incoming lookup address
    // against the current (pre-write) table contents.
    for (genvar g = 0; g < NrRegions; g++) begin : g_match
        pma_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .addr_i (lookup_addr_i),
            .base_i (table_q[g].base[AddrWidth-1:0]),
            .len_i  (table_q[g].len[AddrWidth-1:0]),
            .hit_o  (match_hit[g])
        );
    end

    // Priority select: walk from the top so the lowest matching index is the
    // last one written and therefore wins.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        sel_attr = PMA_ATTR_DEFAULT;
        for (int i = NrRegions - 1; i >= 0; i--) begin
            if (match_hit[i]) begin
                sel_hit  = 1'b1;
                sel_idx  = IdxWidth'(i);
                sel_attr = table_q[i].attr;
            end
        end
    end

    // Config decode. The addressed entry is picked with an explicit compare so
    // an out-of-range index never indexes past the table; it just errors.
    always_comb begin
        cfg_entry  = '0;
        for (int i = 0; i < NrRegions; i++) begin
            if (cfg_idx_i == IdxWidth'(i)) begin
                cfg_entry = table_q[i];
            end
        end
        cfg_idx_ok = 32'(cfg_idx_i) < NrRegions;
        cfg_err    = !cfg_idx_ok || (cfg_field_i == 2'd3) || (cfg_we_i && cfg_entry.attr.l);
        cfg_wr_en  = cfg_req_i && cfg_we_i && !cfg_err;
        case (cfg_field_i)
            BASE:    cfg_rd_val = cfg_entry.base[AddrWidth-1:0];
            LEN:     cfg_rd_val = cfg_entry.len[AddrWidth-1:0];
            ATTR:    cfg_rd_val = AddrWidth'(cfg_entry.attr);
            default: cfg_rd_val = '0;
        endcase
    end

    // Table storage. Writing attr with L set locks the entry in the same
    // update; the lock itself blocks every later write until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRegions; i++) begin
                table_q[i].base <= PMA_MAX_AW'(RstBase[i]);
                table_q[i].len  <= PMA_MAX_AW'(RstLen[i]);
                table_q[i].attr <= pma_attr_t'(RstAttr[i]);
            end
        end else if (cfg_wr_en) begin
            for (int i = 0; i < NrRegions; i++) begin
                if (cfg_idx_i == IdxWidth'(i)) begin
                    case (cfg_field_i)
                        BASE:    table_q[i].base <= PMA_MAX_AW'(cfg_wdata_i);
                        LEN:     table_q[i].len  <= PMA_MAX_AW'(cfg_wdata_i);
                        ATTR:    table_q[i].attr <= pma_attr_t'(cfg_wdata_i[3:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Config response register: one pulse per request, read data only on a
    // successful read so stale values never leak out on writes or errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && cfg_err;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !cfg_err) ? cfg_rd_val : '0;
        end
    end

    assign lookup_ready_o = !resp_valid_o || resp_ready_i;

    // Lookup response register. A stalled response is frozen, so a config
    // write landing during the stall does not change what the consumer sees.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_idx_o   <= '0;
            resp_attr_o  <= '0;
        end else if (lookup_valid_i && lookup_ready_o) begin
            resp_valid_o <= 1'b1;
            resp_hit_o   <= sel_hit;
            resp_idx_o   <= sel_idx;
            resp_attr_o  <= pma_resp_attr(sel_attr);
        end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pma_region_table.sv
// ---------------------------------------------------------------------------
// tb_pma_region_table
// Self-checking bench for pma_region_table: directed scenarios followed by a
// randomized phase, all compared against a behavioural table model.
// ---------------------------------------------------------------------------
module tb_pma_region_table;

    localparam int NR = 8;
    localparam int AW = 64;
    localparam logic [NR-1:0][AW-1:0] TB_RST_BASE = {{(NR-1){64'h0}}, 64'h8000_0000};
    localparam logic [NR-1:0][AW-1:0] TB_RST_LEN  = {{(NR-1){64'h0}}, 64'h4000_0000};
    localparam logic [NR-1:0][3:0]    TB_RST_ATTR = {{(NR-1){4'h0}}, 4'b0111};

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [2:0] attr;
    } lk_t;

    logic          clk;
    logic          rst_n;
    logic          cfg_req;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    logic [1:0]    cfg_field;
    logic [AW-1:0] cfg_wdata;
    logic          cfg_rvalid;
    logic [AW-1:0] cfg_rdata;
    logic          cfg_err;
    logic          lookup_valid;
    logic          lookup_ready;
    logic [AW-1:0] lookup_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_hit;
    logic [2:0]    resp_idx;
    logic [2:0]    resp_attr;

    int checks;
    int errors;

    // Behavioural model of the table and of the response register.
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [3:0]  m_attr [NR];
    logic        m_rvalid;
    lk_t         m_resp;

    pma_region_table #(
        .NrRegions (NR),
        .AddrWidth (AW),
        .RstBase   (TB_RST_BASE),
        .RstLen    (TB_RST_LEN),
        .RstAttr   (TB_RST_ATTR)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_req_i      (cfg_req),
        .cfg_we_i       (cfg_we),
        .cfg_idx_i      (cfg_idx),
        .cfg_field_i    (cfg_field),
        .cfg_wdata_i    (cfg_wdata),
        .cfg_rvalid_o   (cfg_rvalid),
        .cfg_rdata_o    (cfg_rdata),
        .cfg_err_o      (cfg_err),
        .lookup_valid_i (lookup_valid),
        .lookup_ready_o (lookup_ready),
        .lookup_addr_i  (lookup_addr),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_hit_o     (resp_hit),
        .resp_idx_o     (resp_idx),
        .resp_attr_o    (resp_attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = TB_RST_BASE[i];
            m_len[i]  = TB_RST_LEN[i];
            m_attr[i] = TB_RST_ATTR[i];
        end
        m_rvalid = 1'b0;
        m_resp   = '0;
    endtask

    // First region (lowest index) containing the address, in 65-bit arithmetic.
    function automatic lk_t modelLookup(input logic [63:0] a);
        lk_t r;
        logic [64:0] lo, hi;
        r = '0;
        for (int i = 0; i < NR; i++) begin
            lo = {1'b0, m_base[i]};
            hi = lo + {1'b0, m_len[i]};
            if (!r.hit && m_len[i] != 64'h0 && {1'b0, a} >= lo && {1'b0, a} < hi) begin
                r.hit  = 1'b1;
                r.idx  = 3'(i);
                r.attr = m_attr[i][2:0];
            end
        end
        return r;
    endfunction

    function automatic logic modelCfgErr(input logic we, input int idx, input logic [1:0] f);
        if (idx >= NR || f == 2'd3) return 1'b1;
        return we && m_attr[idx][3];
    endfunction

    function automatic logic [63:0] modelRead(input int idx, input logic [1:0] f);
        case (f)
            2'd0:    return m_base[idx];
            2'd1:    return m_len[idx];
            2'd2:    return {60'h0, m_attr[idx]};
            default: return 64'h0;
        endcase
    endfunction

    task automatic modelWrite(input int idx, input logic [1:0] f, input logic [63:0] d);
        case (f)
            2'd0:    m_base[idx] = d;
            2'd1:    m_len[idx]  = d;
            2'd2:    m_attr[idx] = d[3:0];
            default: ;
        endcase
    endtask

    // One config access on an otherwise idle lookup side.
    task automatic configAccess(input string tag, input logic we, input logic [2:0] idx,
                                input logic [1:0] f, input logic [63:0] wd);
        logic        err_e;
        logic [63:0] rd_e;
        err_e = modelCfgErr(we, int'(idx), f);
        rd_e  = modelRead(int'(idx), f);
        if (we && !err_e) modelWrite(int'(idx), f, wd);
        cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = f; cfg_wdata = wd;
        step();
        cfg_req = 1'b0; cfg_we = 1'b0;
        checkOutput({tag, "_rvalid"}, 64'(cfg_rvalid), 64'h1);
        checkOutput({tag, "_err"}, 64'(cfg_err), 64'(err_e));
        if (!we && !err_e) checkOutput({tag, "_rdata"}, cfg_rdata, rd_e);
    endtask

    // One lookup with the consumer ready; result checked the next cycle.
    task automatic doLookup(input string tag, input logic [63:0] a);
        lk_t e;
        e = modelLookup(a);
        lookup_valid = 1'b1; lookup_addr = a; resp_ready = 1'b1;
        checkOutput({tag, "_lready"}, 64'(lookup_ready), 64'h1);
        step();
        lookup_valid = 1'b0;
        checkOutput({tag, "_valid"}, 64'(resp_valid), 64'h1);
        checkOutput({tag, "_hit"}, 64'(resp_hit), 64'(e.hit));
        checkOutput({tag, "_idx"}, 64'(resp_idx), 64'(e.idx));
        checkOutput({tag, "_attr"}, 64'(resp_attr), 64'(e.attr));
    endtask

    // One randomized cycle: config traffic, lookups and consumer backpressure.
    task automatic applyStimulus();
        logic        req, we, vld, rdy, hs, err_e;
        logic [2:0]  idx;
        logic [1:0]  f;
        logic [63:0] wd, a, rd_e;
        lk_t         lk;
        req = ($urandom_range(0, 2) == 0);
        we  = 1'($urandom_range(0, 1));
        idx = 3'($urandom_range(0, 7));
        f   = 2'($urandom_range(0, 3));
        case (f)
            2'd0:    wd = 64'($urandom_range(0, 15)) << 12;
            2'd1:    wd = 64'($urandom_range(0, 4)) << 12;
            default: wd = {60'h0, ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7))};
        endcase
        vld = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        a   = 64'($urandom_range(0, 'h13FFF));
        cfg_req = req; cfg_we = we; cfg_idx = idx; cfg_field = f; cfg_wdata = wd;
        lookup_valid = vld; lookup_addr = a; resp_ready = rdy;
        #1;
        checkOutput("rnd_lready", 64'(lookup_ready), 64'(!m_rvalid || rdy));
        hs    = vld && (!m_rvalid || rdy);
        lk    = modelLookup(a);
        err_e = modelCfgErr(we, int'(idx), f);
        rd_e  = modelRead(int'(idx), f);
        if (req && we && !err_e) modelWrite(int'(idx), f, wd);
        if (hs) begin
            m_rvalid = 1'b1;
            m_resp   = lk;
        end else if (rdy) begin
            m_rvalid = 1'b0;
        end
        step();
        checkOutput("rnd_valid", 64'(resp_valid), 64'(m_rvalid));
        if (m_rvalid) begin
            checkOutput("rnd_hit", 64'(resp_hit), 64'(m_resp.hit));
            checkOutput("rnd_idx", 64'(resp_idx), 64'(m_resp.idx));
            checkOutput("rnd_attr", 64'(resp_attr), 64'(m_resp.attr));
        end
        checkOutput("rnd_cfg_rvalid", 64'(cfg_rvalid), 64'(req));
        if (req) begin
            checkOutput("rnd_cfg_err", 64'(cfg_err), 64'(err_e));
            if (!we && !err_e) checkOutput("rnd_cfg_rdata", cfg_rdata, rd_e);
        end
    endtask

    initial begin
        lk_t         held, e;
        logic [63:0] rel_addr [4];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
        lookup_valid = 1'b0; lookup_addr = '0; resp_ready = 1'b1;
        modelReset();

        // Reset state
        repeat (2) step();
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'h0);
        checkOutput("rst_resp_hit", 64'(resp_hit), 64'h0);
        checkOutput("rst_resp_idx", 64'(resp_idx), 64'h0);
        checkOutput("rst_resp_attr", 64'(resp_attr), 64'h0);
        checkOutput("rst_cfg_rvalid", 64'(cfg_rvalid), 64'h0);
        checkOutput("rst_cfg_rdata", cfg_rdata, 64'h0);
        checkOutput("rst_cfg_err", 64'(cfg_err), 64'h0);
        rst_n = 1'b1;
        step();

        // Reset-loaded table contents and lookups against entry 0
        configAccess("rd_base0", 1'b0, 3'd0, 2'd0, 64'h0);
        configAccess("rd_len0", 1'b0, 3'd0, 2'd1, 64'h0);
        configAccess("rd_attr0", 1'b0, 3'd0, 2'd2, 64'h0);
        doLookup("lk_reset_hit", 64'h8000_1000);
        doLookup("lk_reset_miss", 64'hC000_0000);
        doLookup("lk_last_in", 64'hBFFF_FFFF);
        doLookup("lk_first_in", 64'h8000_0000);
        doLookup("lk_below", 64'h7FFF_FFFF);

        // Region wrapping past the top of the address space
        configAccess("wr_wrap_base", 1'b1, 3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        configAccess("wr_wrap_len", 1'b1, 3'd0, 2'd1, 64'h2000);
        doLookup("lk_wrap_top", 64'hFFFF_FFFF_FFFF_FFFF);
        doLookup("lk_wrap_zero", 64'h0);
        doLookup("lk_wrap_base", 64'hFFFF_FFFF_FFFF_F000);
        doLookup("lk_wrap_below", 64'hFFFF_FFFF_FFFF_EFFF);
        doLookup("lk_wrap_alias", 64'h0FFF);

        // Priority between overlapping regions
        configAccess("wr_e1_base", 1'b1, 3'd1, 2'd0, 64'h1_0000);
        configAccess("wr_e1_len", 1'b1, 3'd1, 2'd1, 64'h1_0000);
        configAccess("wr_e1_attr", 1'b1, 3'd1, 2'd2, 64'b0100);
        configAccess("wr_e3_base", 1'b1, 3'd3, 2'd0, 64'h0);
        configAccess("wr_e3_len", 1'b1, 3'd3, 2'd1, 64'h10_0000);
        configAccess("wr_e3_attr", 1'b1, 3'd3, 2'd2, 64'b0001);
        doLookup("lk_prio", 64'h1_8000);
        doLookup("lk_prio_edge", 64'h2_0000);
        doLookup("lk_prio_low", 64'h1_0000);
        doLookup("lk_prio_e3_top", 64'hF_FFFF);

        // Lock bit
        configAccess("lock_set", 1'b1, 3'd2, 2'd2, 64'b1101);
        configAccess("lock_wr_base", 1'b1, 3'd2, 2'd0, 64'h1234_0000);
        configAccess("lock_rd_base", 1'b0, 3'd2, 2'd0, 64'h0);
        configAccess("lock_wr_attr", 1'b1, 3'd2, 2'd2, 64'b0000);
        configAccess("lock_rd_attr", 1'b0, 3'd2, 2'd2, 64'h0);

        // Reserved field, and a single-cycle response pulse
        configAccess("fld3_rd", 1'b0, 3'd4, 2'd3, 64'h0);
        configAccess("fld3_wr", 1'b1, 3'd4, 2'd3, 64'hFFFF);
        step();
        checkOutput("cfg_pulse_drop", 64'(cfg_rvalid), 64'h0);

        // Backpressure: capture, stall three cycles with a write underneath, release
        held = modelLookup(64'h1_8000);
        lookup_valid = 1'b1; lookup_addr = 64'h1_8000; resp_ready = 1'b0;
        step();
        lookup_addr = 64'h2_0000;
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_lready", 64'(lookup_ready), 64'h0);
            if (k == 1) begin
                cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd1; cfg_field = 2'd1; cfg_wdata = 64'h0;
                modelWrite(1, 2'd1, 64'h0);
            end
            step();
            cfg_req = 1'b0; cfg_we = 1'b0;
            if (k == 1) checkOutput("bp_cfg_err", 64'(cfg_err), 64'h0);
            checkOutput("bp_valid", 64'(resp_valid), 64'h1);
            checkOutput("bp_hit", 64'(resp_hit), 64'(held.hit));
            checkOutput("bp_idx", 64'(resp_idx), 64'(held.idx));
            checkOutput("bp_attr", 64'(resp_attr), 64'(held.attr));
        end
        rel_addr[0] = 64'h1_8000; rel_addr[1] = 64'h5_0000;
        rel_addr[2] = 64'h0;      rel_addr[3] = 64'h1_0000;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = modelLookup(rel_addr[k]);
            lookup_addr = rel_addr[k];
            step();
            checkOutput("rel_valid", 64'(resp_valid), 64'h1);
            checkOutput("rel_hit", 64'(resp_hit), 64'(e.hit));
            checkOutput("rel_idx", 64'(resp_idx), 64'(e.idx));
            checkOutput("rel_attr", 64'(resp_attr), 64'(e.attr));
        end
        lookup_valid = 1'b0;
        step();
        checkOutput("rel_drain", 64'(resp_valid), 64'h0);

        // Config write and lookup in the same cycle: lookup sees the old table
        e = modelLookup(64'hFFFF_FFFF_FFFF_F800);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_field = 2'd1; cfg_wdata = 64'h0;
        lookup_valid = 1'b1; lookup_addr = 64'hFFFF_FFFF_FFFF_F800;
        modelWrite(0, 2'd1, 64'h0);
        step();
        cfg_req = 1'b0; cfg_we = 1'b0;
        checkOutput("sim_cfg_err", 64'(cfg_err), 64'h0);
        checkOutput("sim_hit", 64'(resp_hit), 64'(e.hit));
        checkOutput("sim_idx", 64'(resp_idx), 64'(e.idx));
        checkOutput("sim_attr", 64'(resp_attr), 64'(e.attr));
        e = modelLookup(64'hFFFF_FFFF_FFFF_F800);
        step();
        lookup_valid = 1'b0;
        checkOutput("sim_next_hit", 64'(resp_hit), 64'(e.hit));
        checkOutput("sim_next_attr", 64'(resp_attr), 64'(e.attr));
        step();
        m_rvalid = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) applyStimulus();
        cfg_req = 1'b0;

        // Reset in the middle of a stalled response and a config response
        lookup_valid = 1'b1; lookup_addr = 64'h1_8000; resp_ready = 1'b0;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_field = 2'd0;
        step();
        checkOutput("mid_pre_valid", 64'(resp_valid), 64'h1);
        checkOutput("mid_pre_cfg_rvalid", 64'(cfg_rvalid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(resp_valid), 64'h0);
        checkOutput("mid_rst_hit", 64'(resp_hit), 64'h0);
        checkOutput("mid_rst_cfg_rvalid", 64'(cfg_rvalid), 64'h0);
        checkOutput("mid_rst_cfg_rdata", cfg_rdata, 64'h0);
        lookup_valid = 1'b0; cfg_req = 1'b0; resp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        modelReset();
        step();
        checkOutput("post_rst_valid", 64'(resp_valid), 64'h0);
        checkOutput("post_rst_cfg_rvalid", 64'(cfg_rvalid), 64'h0);
        configAccess("post_rst_attr2", 1'b0, 3'd2, 2'd2, 64'h0);
        configAccess("post_rst_unlock", 1'b1, 3'd2, 2'd0, 64'h4000);
        doLookup("post_rst_lk", 64'h8000_1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical-memory-attribute (PMA) table for the CVA6 core. It generalises the fixed cached, non-idempotent and execute region rules into NrRegions programmable entries. Each entry has a base, a length, an attribute set and a lock bit. A registered lookup pipeline with a valid/ready handshake serves the fetch, LSU or PTW requester. A single-cycle configuration port with a registered response sits on the CSR/debug side.

## Interface
- NrRegions, 8: number of region entries, 1..16.
- AddrWidth, 64: physical address width.
- RstBase, '0: per-entry base reset values, NrRegions x AddrWidth.
- RstLen, '0: per-entry length reset values, NrRegions x AddrWidth.
- RstAttr, '0: per-entry attribute reset values, NrRegions x 4 bits {L,X,I,C}.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_req_i  in  1  config access, single-cycle pulse.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  $clog2(NrRegions)  entry index.
- cfg_field_i  in  2  field select: 0 = base, 1 = length, 2 = attr, 3 = reserved.
- cfg_wdata_i  in  AddrWidth  write data; attr uses bits [3:0].
- cfg_rvalid_o  out  1  response valid, one cycle after cfg_req_i.
- cfg_rdata_o  out  AddrWidth  read data, zero-extended.
- cfg_err_o  out  1  error flag, valid with cfg_rvalid_o.
- lookup_valid_i  in  1  lookup request.
- lookup_ready_o  out  1  pipeline can accept a lookup.
- lookup_addr_i  in  AddrWidth  physical address.
- resp_valid_o  out  1  lookup result valid.
- resp_ready_i  in  1  consumer accepts the result.
- resp_hit_o  out  1  some entry matched.
- resp_idx_o  out  $clog2(NrRegions)  index of the winning entry.
- resp_attr_o  out  3  {X,I,C} of the winning entry; 0 on miss.

## Operation
- Match rule: base <= addr < base+len.
  - Compute in AddrWidth+1 bits so that base+len wraps above the top of the address space without aliasing.
  - len == 0 disables the entry.
- Priority: the lowest matching index wins. On no match: hit = 0, idx = 0, attr = 3'b000 (uncached, non-idempotent, non-executable).
- Lock bit L (attr[3]):
  - While L = 1, writes to any field of that entry are dropped and cfg_err_o = 1.
  - L clears only on reset.
  - Writing attr with L = 1 sets the lock atomically with X/I/C.
- Config errors, each giving cfg_err_o = 1 with no state change:
  - cfg_field_i == 3.
  - cfg_idx_i >= NrRegions.
- Reads return base, length or {AddrWidth-4 zeros, L,X,I,C}. Reads never error except under the index and field rules above.
- Lookup pipeline, one stage:
  - lookup_ready_o = !resp_valid_o || resp_ready_i.
  - A handshake (valid & ready) captures the result into the response register.
  - The response holds stable while resp_valid_o = 1 and resp_ready_i = 0.
- Simultaneous config write and lookup handshake in the same cycle: the lookup sees the pre-write table. The write takes effect for lookups accepted from the next cycle.
- A held (stalled) response is not re-evaluated after a config write.

## Timing
- Reset (rst_ni low, asynchronous):
  - Table loads RstBase/RstLen/RstAttr.
  - resp_valid_o = 0, resp_hit_o = 0, resp_idx_o = 0, resp_attr_o = 0.
  - cfg_rvalid_o = 0, cfg_rdata_o = 0, cfg_err_o = 0.
- Lookup latency is exactly 1 cycle from handshake to resp_valid_o. Throughput is 1 per cycle when resp_ready_i = 1.
- Config latency is 1 cycle. cfg_rvalid_o pulses for exactly one cycle per cfg_req_i; back-to-back requests are allowed.
- Reset asserted mid-transaction drops the in-flight response. No response is issued after deassertion for a pre-reset request.

## Structure
- Shared package pma_pkg: pma_attr_t (packed {l,x,i,c}), pma_field_e (BASE, LEN, ATTR), pma_entry_t, PMA_ATTR_DEFAULT.
- Sub-module pma_match: combinational single-entry comparator (addr, base, len -> hit). Instantiate it NrRegions times; a leading-one priority select follows it.
- Target size is about 200 RTL lines.

## Test plan
- Reset check: RstBase[0]=0x8000_0000, RstLen[0]=0x4000_0000, RstAttr[0]=4'b0111.
  - Lookup 0x8000_1000 -> next cycle hit = 1, idx = 0, attr = 3'b111.
  - Lookup 0xC000_0000 -> hit = 0, attr = 0.
- Priority:
  - Program entry 1 = {0x1_0000, 0x1_0000, X} and entry 3 = {0x0, 0x10_0000, C}.
  - Lookup 0x1_8000 -> idx = 1, attr = 3'b100.
- Wrap and bounds: entry 0 base = 2^64-0x1000, len = 0x2000.
  - Lookup 0xFFFF_FFFF_FFFF_FFFF -> hit.
  - Lookup 0x0 -> miss.
  - Lookup base+len-1 hits; base+len misses (boundary).
- Lock:
  - Write attr = 4'b1101 to entry 2 -> err = 0.
  - Write base to entry 2 -> err = 1; readback unchanged; L persists until reset.
- Backpressure: hold resp_ready_i = 0 for 3 cycles with lookup_valid_i = 1.
  - lookup_ready_o = 0 and the response stays stable.
  - A config write during the stall does not alter the held response.
  - Release -> 1 result per cycle.
- Errors and simultaneity:
  - cfg_field_i = 3 -> err = 1.
  - Write len = 0 to entry 0 in the same cycle as a lookup handshake -> that lookup still hits; the next lookup misses.
